// File: rtl/bip_pkg.sv
// Shared widths, opcode constants and fetch-state encoding for the BIP processor.
package bip_pkg;

  localparam int NB_OPCODE      = 5;
  localparam int NB_OPERAND     = 11;
  localparam int NB_INSTRUCTION = NB_OPCODE + NB_OPERAND;
  localparam int NB_PC          = 11;
  localparam int NB_COUNT       = 16;

  localparam logic [NB_OPCODE-1:0] OP_HALT = 5'b00000;
  localparam logic [NB_OPCODE-1:0] OP_STO  = 5'b00001;
  localparam logic [NB_OPCODE-1:0] OP_LD   = 5'b00010;
  localparam logic [NB_OPCODE-1:0] OP_LDI  = 5'b00011;
  localparam logic [NB_OPCODE-1:0] OP_ADD  = 5'b00100;
  localparam logic [NB_OPCODE-1:0] OP_ADDI = 5'b00101;
  localparam logic [NB_OPCODE-1:0] OP_SUB  = 5'b00110;
  localparam logic [NB_OPCODE-1:0] OP_SUBI = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/bip_program_memory.sv
// Program RAM: one write port, one synchronous read port with read enable.
// The read-data register doubles as the instruction register, so it is reset.
module bip_program_memory #(
  parameter int NB_DATA = 16,
  parameter int NB_ADDR = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [NB_ADDR-1:0] wr_addr,
  input  logic [NB_DATA-1:0] wr_data,
  input  logic               rd_en,
  input  logic [NB_ADDR-1:0] rd_addr,
  output logic [NB_DATA-1:0] rd_data
);

  localparam int DEPTH = 1 << NB_ADDR;

  logic [NB_DATA-1:0] mem [DEPTH];

  // The array itself is never reset; contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bip_fetch_unit.sv
// BIP instruction fetch/sequencer: PC, program RAM, IDLE/FETCH/EXEC/HALTED FSM.
// Define BIP_FETCH_INSN_COUNT_EN to build the saturating retired-instruction counter.
module bip_fetch_unit #(
  parameter int NB_OPCODE      = bip_pkg::NB_OPCODE,
  parameter int NB_OPERAND     = bip_pkg::NB_OPERAND,
  parameter int NB_INSTRUCTION = bip_pkg::NB_INSTRUCTION,
  parameter int NB_PC          = bip_pkg::NB_PC
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic                      i_wrPc,
  input  logic                      i_load_valid,
  input  logic [NB_PC-1:0]          i_load_addr,
  input  logic [NB_INSTRUCTION-1:0] i_load_data,
  output logic                      o_load_ready,
  output logic [NB_OPCODE-1:0]      o_opcode,
  output logic [NB_OPERAND-1:0]     o_operand,
  output logic                      o_valid,
  output logic [NB_PC-1:0]          o_pc,
  output logic                      o_halted,
  output logic                      o_running,
  output logic [15:0]               o_insn_count,
  output bip_pkg::fetch_state_t     o_state
);

  import bip_pkg::*;

  fetch_state_t              state;
  logic [NB_PC-1:0]          pc;
  logic [NB_INSTRUCTION-1:0] ir;
  logic                      stopped;
  logic                      start_ok;
  logic                      load_ok;
  logic                      is_halt;

  // Load handshake: a word is written on a cycle where i_load_valid and
  // o_load_ready are both high. Ready is only offered while stopped, and a
  // same-cycle i_start wins, so that load is dropped rather than written.
  assign stopped      = (state == ST_IDLE) || (state == ST_HALTED);
  assign start_ok     = stopped && i_start;
  assign o_load_ready = stopped && !i_start;
  assign load_ok      = i_load_valid && o_load_ready;

  assign o_opcode  = ir[NB_INSTRUCTION-1 -: NB_OPCODE];
  assign o_operand = ir[NB_OPERAND-1:0];
  assign is_halt   = (o_opcode == NB_OPCODE'(OP_HALT));
  assign o_pc      = pc;
  assign o_state   = state;

  bip_program_memory #(
    .NB_DATA (NB_INSTRUCTION),
    .NB_ADDR (NB_PC)
  ) u_program_memory (
    .clk     (i_clock),
    .rst_n   (i_reset),
    .wr_en   (load_ok),
    .wr_addr (i_load_addr),
    .wr_data (i_load_data),
    .rd_en   (state == ST_FETCH),
    .rd_addr (pc),
    .rd_data (ir)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= ST_IDLE;
      pc        <= '0;
      o_valid   <= 1'b0;
      o_halted  <= 1'b0;
      o_running <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start_ok) begin
            pc        <= '0;
            o_halted  <= 1'b0;
            o_running <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          o_valid <= 1'b1;
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          // HALT takes priority; its PC stays frozen at the HALT address.
          if (is_halt) begin
            o_valid   <= 1'b0;
            o_halted  <= 1'b1;
            o_running <= 1'b0;
            state     <= ST_HALTED;
          end else if (i_wrPc) begin
            pc      <= pc + NB_PC'(1);
            o_valid <= 1'b0;
            state   <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BIP_FETCH_INSN_COUNT_EN
  logic [15:0] insn_count;

  // A HALT counts once: EXEC with a HALT opcode lasts exactly one cycle.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      insn_count <= '0;
    end else if (start_ok) begin
      insn_count <= '0;
    end else if ((state == ST_EXEC) && (is_halt || i_wrPc) && (insn_count != 16'hFFFF)) begin
      insn_count <= insn_count + 16'd1;
    end
  end

  assign o_insn_count = insn_count;
`else
  assign o_insn_count = '0;
`endif

endmodule

// File: tb/tb_bip_fetch_unit.sv
// Directed bench for bip_fetch_unit: program-level model plus hand-computed expectations.
`timescale 1ns/1ps
module tb_bip_fetch_unit;

  import bip_pkg::*;

`ifdef BIP_FETCH_INSN_COUNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic        wr_pc = 1'b0;
  logic        load_valid = 1'b0;
  logic [10:0] load_addr = '0;
  logic [15:0] load_data = '0;
  logic        load_ready;
  logic [4:0]  opcode;
  logic [10:0] operand;
  logic        valid;
  logic [10:0] pc;
  logic        halted;
  logic        running;
  logic [15:0] insn_count;
  fetch_state_t state_dbg;

  always #5 clk = ~clk;

  bip_fetch_unit dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_start      (start),
    .i_wrPc       (wr_pc),
    .i_load_valid (load_valid),
    .i_load_addr  (load_addr),
    .i_load_data  (load_data),
    .o_load_ready (load_ready),
    .o_opcode     (opcode),
    .o_operand    (operand),
    .o_valid      (valid),
    .o_pc         (pc),
    .o_halted     (halted),
    .o_running    (running),
    .o_insn_count (insn_count),
    .o_state      (state_dbg)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- program-level model ----------------
  // Tracks whether a program is running, whether an instruction is on show,
  // the program counter and the word being shown.
  logic [15:0] m_mem [2048];
  bit          m_busy, m_show, m_halted;
  logic [10:0] m_pc;
  logic [15:0] m_word;
  int unsigned m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_show = 0; m_halted = 0;
      m_pc = '0; m_word = '0; m_cnt = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_show = 0; m_halted = 0; m_pc = '0; m_cnt = 0;
      end else if (load_valid) begin
        m_mem[load_addr] = load_data;
      end
    end else if (!m_show) begin
      m_word = m_mem[m_pc];
      m_show = 1;
    end else if (m_word[15:11] == 5'd0) begin
      m_busy = 0; m_show = 0; m_halted = 1; m_cnt++;
    end else if (wr_pc) begin
      m_pc = m_pc + 11'd1; m_show = 0; m_cnt++;
    end
  end

  function automatic logic [15:0] exp_cnt();
`ifdef BIP_FETCH_INSN_COUNT_EN
    return (m_cnt > 65535) ? 16'hFFFF : m_cnt[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  // ---------------- compare process ----------------
  bit          prev_valid = 0;
  logic [15:0] exp_e;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_valid = 0;
    end else begin
      check("valid",      valid,      m_show);
      check("running",    running,    m_busy);
      check("halted",     halted,     m_halted);
      check("pc",         pc,         m_pc);
      check("opcode",     opcode,     m_word[15:11]);
      check("operand",    operand,    m_word[10:0]);
      check("load_ready", load_ready, !m_busy && !start);
      check("insn_count", insn_count, exp_cnt());
      if (valid && !prev_valid && exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        check("fetch_seq", {pc, opcode}, exp_e);
      end
      prev_valid = valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_word(input logic [10:0] a, input logic [15:0] d);
    load_valid = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_prog3();
    exp_q.push_back({11'd0, 5'd3});
    exp_q.push_back({11'd1, 5'd5});
    exp_q.push_back({11'd2, 5'd0});
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!valid && n < max) begin @(negedge clk); n++; end
    check("wait_valid_timeout", valid, 1'b1);
  endtask

  task automatic wait_halted(input int max, output int n);
    n = 0;
    while (!halted && n < max) begin @(negedge clk); n++; end
    check("wait_halted_timeout", halted, 1'b1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid",   valid,      0);
    check("rst_halted",  halted,     0);
    check("rst_running", running,    0);
    check("rst_pc",      pc,         0);
    check("rst_opcode",  opcode,     0);
    check("rst_count",   insn_count, 0);
    check("rst_state",   32'(state_dbg), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_load_ready", load_ready, 1);

    // Program: LDI 5, ADDI 3, HALT with immediate consumption.
    wr_pc = 1'b1;
    load_word(11'd0, 16'h1805);
    load_word(11'd1, 16'h2803);
    load_word(11'd2, 16'h0000);
    push_prog3();
    pulse_start();
    wait_halted(20, n);
    check("halt_latency", n, 6);
    check("halt_pc", pc, 2);
    check("prog_count", insn_count, CNT_ON ? 3 : 0);
    check("prog_seq_drained", exp_q.size(), 0);

    // Stall four cycles in the first EXEC.
    wr_pc = 1'b0;
    push_prog3();
    pulse_start();
    wait_valid(5);
    repeat (4) begin
      check("stall_valid",   valid,   1);
      check("stall_opcode",  opcode,  3);
      check("stall_operand", operand, 5);
      check("stall_pc",      pc,      0);
      @(negedge clk);
    end
    wr_pc = 1'b1;
    wait_halted(20, n);
    check("stall_halt_pc", pc, 2);
    check("stall_count", insn_count, CNT_ON ? 3 : 0);
    check("stall_seq_drained", exp_q.size(), 0);

    // Asynchronous reset in the middle of EXEC.
    wr_pc = 1'b0;
    pulse_start();
    wait_valid(5);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid",   valid,      0);
    check("arst_running", running,    0);
    check("arst_halted",  halted,     0);
    check("arst_pc",      pc,         0);
    check("arst_opcode",  opcode,     0);
    check("arst_count",   insn_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_load_ready", load_ready, 1);
    check("arst_idle", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk);

    // Start beats a same-cycle load; a load during EXEC is ignored.
    wr_pc = 1'b1;
    push_prog3();
    start = 1'b1; load_valid = 1'b1; load_addr = 11'd0; load_data = 16'h0000;
    #1 check("start_blocks_load", load_ready, 0);
    @(negedge clk);
    start = 1'b0; load_valid = 1'b0;
    wait_valid(5);
    load_word(11'd1, 16'h0000);
    wait_halted(20, n);
    check("collide_halt_pc", pc, 2);
    check("collide_seq_drained", exp_q.size(), 0);
    push_prog3();
    pulse_start();
    wait_halted(20, n);
    check("rerun_halt_pc", pc, 2);
    check("rerun_seq_drained", exp_q.size(), 0);

    // Reload from HALTED: immediate HALT at address 0.
    load_word(11'd0, 16'h0000);
    exp_q.push_back({11'd0, 5'd0});
    pulse_start();
    check("restart_halted_drop", halted, 0);
    check("restart_count_zero", insn_count, 0);
    wait_halted(10, n);
    check("halt0_latency", n, 2);
    check("halt0_pc", pc, 0);
    check("halt0_count", insn_count, CNT_ON ? 1 : 0);
    check("halt0_seq_drained", exp_q.size(), 0);

    // PC wrap: every word is opcode 1, PC runs 0..2047 then back to 0.
    wr_pc = 1'b1;
    for (int i = 0; i < 2048; i++) load_word(11'(i), 16'h0800);
    for (int i = 0; i < 2048; i++) exp_q.push_back({11'(i), 5'd1});
    exp_q.push_back({11'd0, 5'd1});
    pulse_start();
    repeat (4097) @(negedge clk);
    #3;
    check("wrap_seq_drained", exp_q.size(), 0);
    check("wrap_pc", pc, 0);
    check("wrap_no_halt", halted, 0);
    check("wrap_count", insn_count, CNT_ON ? 2048 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
